mem_boot_loader: RTL and testbench

- Byte-stream boot loader that drives the CPU top's external data-memory write port (Ext_MemWrite, Ext_DataAdr, Ext_WriteData) and owns the CPU reset.
- Holds the CPU in reset and receives bytes over a valid/ready stream, assembling them little-endian into 32-bit words.
- Writes each word to consecutive word addresses, then releases the CPU reset so the program runs on the loaded data.
- Sits between the host-link receiver and the CPU top; its outputs connect directly to that top's reset and Ext_* inputs.

---
 rtl/mem_boot_loader.sv | 91 +++++++++
 tb/tb_mem_boot_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_boot_loader.sv
// Byte-stream boot loader: assembles little-endian words from a valid/ready byte
// stream, writes them to consecutive data-memory words, then releases the CPU reset.
module mem_boot_loader #(
  parameter int          NUM_WORDS = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        boot_req,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_DataAdr,
  output logic [31:0] Ext_WriteData,
  output logic        done,
  output logic [15:0] word_count
);

  typedef enum logic [1:0] {LOAD, WRITE, RELEASE, RUN} state_t;

  localparam logic [15:0] NumWordsC = 16'(NUM_WORDS);

  state_t      stateQ, stateD;
  logic [1:0]  byteIdx;
  logic [23:0] shiftReg;
  logic [31:0] dataAdr;
  logic [31:0] writeData;
  logic [15:0] wordCnt;
  logic        accept;
  logic        lastWord;

  // rx_ready is gated by reset so nothing is offered while reset is held high
  assign rx_ready     = (stateQ == LOAD) && !reset;
  assign accept       = rx_valid && rx_ready;
  assign lastWord     = (wordCnt + 16'd1) == NumWordsC;
  assign cpu_reset    = (stateQ != RUN);
  assign Ext_MemWrite = (stateQ == WRITE);
  assign done         = (stateQ == RUN);
  assign Ext_DataAdr   = dataAdr;
  assign Ext_WriteData = writeData;
  assign word_count    = wordCnt;

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      LOAD:    if (accept && byteIdx == 2'd3) stateD = WRITE;
      WRITE:   stateD = lastWord ? RELEASE : LOAD;
      RELEASE: stateD = RUN;
      RUN:     if (boot_req) stateD = LOAD;
      default: stateD = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateQ <= LOAD;
    else       stateQ <= stateD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byteIdx   <= 2'd0;
      shiftReg  <= 24'd0;
      dataAdr   <= BASE_ADDR;
      writeData <= 32'd0;
      wordCnt   <= 16'd0;
    end else begin
      if (accept) begin
        byteIdx <= byteIdx + 2'd1;
        case (byteIdx)
          2'd0:    shiftReg[7:0]   <= rx_data;
          2'd1:    shiftReg[15:8]  <= rx_data;
          2'd2:    shiftReg[23:16] <= rx_data;
          default: writeData       <= {rx_data, shiftReg};
        endcase
      end
      // Address advances after each write so it always names the next target word
      if (stateQ == WRITE) begin
        wordCnt <= wordCnt + 16'd1;
        dataAdr <= dataAdr + 32'd4;
      end
      if (stateQ == RUN && boot_req) begin
        wordCnt <= 16'd0;
        byteIdx <= 2'd0;
        dataAdr <= BASE_ADDR;
      end
    end
  end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader: two instances (2 words at 0x0, 3 words at 0x100).
module tb_mem_boot_loader;

  logic        clk;
  logic        reset;
  logic        rxValid0, rxValid1;
  logic [7:0]  rxData0, rxData1;
  logic        rxReady0, rxReady1;
  logic        bootReq0, bootReq1;
  logic        cpuReset0, cpuReset1;
  logic        mw0, mw1;
  logic [31:0] adr0, adr1;
  logic [31:0] wd0, wd1;
  logic        done0, done1;
  logic [15:0] wc0, wc1;

  int total = 0;
  int bad = 0;

  logic [31:0] logAdr0 [16];
  logic [31:0] logDat0 [16];
  logic [31:0] logAdr1 [16];
  logic [31:0] logDat1 [16];
  int nWr0 = 0;
  int nWr1 = 0;
  logic prevMw0 = 1'b0;
  logic prevMw1 = 1'b0;

  mem_boot_loader #(.NUM_WORDS(2), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clk(clk), .reset(reset), .rx_valid(rxValid0), .rx_data(rxData0),
    .rx_ready(rxReady0), .boot_req(bootReq0), .cpu_reset(cpuReset0),
    .Ext_MemWrite(mw0), .Ext_DataAdr(adr0), .Ext_WriteData(wd0),
    .done(done0), .word_count(wc0)
  );

  mem_boot_loader #(.NUM_WORDS(3), .BASE_ADDR(32'h0000_0100)) dut1 (
    .clk(clk), .reset(reset), .rx_valid(rxValid1), .rx_data(rxData1),
    .rx_ready(rxReady1), .boot_req(bootReq1), .cpu_reset(cpuReset1),
    .Ext_MemWrite(mw1), .Ext_DataAdr(adr1), .Ext_WriteData(wd1),
    .done(done1), .word_count(wc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle write capture and invariant checks for both instances
  always @(negedge clk) begin
    if (mw0 && nWr0 < 16) begin
      logAdr0[nWr0] = adr0;
      logDat0[nWr0] = wd0;
      nWr0++;
    end
    if (mw1 && nWr1 < 16) begin
      logAdr1[nWr1] = adr1;
      logDat1[nWr1] = wd1;
      nWr1++;
    end
    total += 6;
    assert (!(mw0 && !cpuReset0)) else begin bad++; $error("FAIL inv0_mw_rst observed mw=%b cpu_reset=%b required cpu_reset=1", mw0, cpuReset0); end
    assert (!(mw0 && prevMw0)) else begin bad++; $error("FAIL inv0_mw_b2b observed two consecutive writes required none"); end
    assert (!(rxReady0 && (mw0 || done0))) else begin bad++; $error("FAIL inv0_ready observed rx_ready=1 required 0"); end
    assert (!(mw1 && !cpuReset1)) else begin bad++; $error("FAIL inv1_mw_rst observed mw=%b cpu_reset=%b required cpu_reset=1", mw1, cpuReset1); end
    assert (!(mw1 && prevMw1)) else begin bad++; $error("FAIL inv1_mw_b2b observed two consecutive writes required none"); end
    assert (!(rxReady1 && (mw1 || done1))) else begin bad++; $error("FAIL inv1_ready observed rx_ready=1 required 0"); end
    prevMw0 <= mw0;
    prevMw1 <= mw1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the byte is taken
  task automatic sendByte(input int sel, input logic [7:0] b, input bit gap);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    if (sel == 0) begin rxValid0 = 1'b1; rxData0 = b; end
    else          begin rxValid1 = 1'b1; rxData1 = b; end
    while (!ok && n < 20) begin
      #1;
      ok = (sel == 0) ? rxReady0 : rxReady1;
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {31'd0, ok}, 32'd1);
    if (gap) begin
      if (sel == 0) rxValid0 = 1'b0;
      else          rxValid1 = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    rxValid0 = 1'b0; rxData0 = 8'h00; bootReq0 = 1'b0;
    rxValid1 = 1'b0; rxData1 = 8'h00; bootReq1 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cpu_reset", {31'd0, cpuReset0}, 32'd1);
    check("rst_mw", {31'd0, mw0}, 32'd0);
    check("rst_ready", {31'd0, rxReady0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_adr", adr0, 32'h0);
    check("rst_wd", wd0, 32'h0);
    check("rst_wc", {16'd0, wc0}, 32'd0);
    check("rst_adr1", adr1, 32'h100);
    reset = 1'b0;

    // Stream held valid: 78 56 34 12 EF BE AD DE
    sendByte(0, 8'h78, 0); sendByte(0, 8'h56, 0); sendByte(0, 8'h34, 0); sendByte(0, 8'h12, 0);
    sendByte(0, 8'hEF, 0); sendByte(0, 8'hBE, 0); sendByte(0, 8'hAD, 0); sendByte(0, 8'hDE, 0);
    check("t1_write_mw", {31'd0, mw0}, 32'd1);
    check("t1_write_adr", adr0, 32'h4);
    check("t1_write_wd", wd0, 32'hDEADBEEF);
    check("t1_write_ready", {31'd0, rxReady0}, 32'd0);
    rxValid0 = 1'b0;
    @(negedge clk);
    check("t1_rel_cpu_reset", {31'd0, cpuReset0}, 32'd1);
    check("t1_rel_done", {31'd0, done0}, 32'd0);
    check("t1_rel_mw", {31'd0, mw0}, 32'd0);
    check("t1_rel_ready", {31'd0, rxReady0}, 32'd0);
    @(negedge clk);
    check("t1_run_cpu_reset", {31'd0, cpuReset0}, 32'd0);
    check("t1_run_done", {31'd0, done0}, 32'd1);
    check("t1_run_wc", {16'd0, wc0}, 32'd2);
    check("t1_nwr", nWr0, 2);
    check("t1_adr0", logAdr0[0], 32'h0);
    check("t1_dat0", logDat0[0], 32'h12345678);
    check("t1_adr1", logAdr0[1], 32'h4);
    check("t1_dat1", logDat0[1], 32'hDEADBEEF);

    // Reboot, then same stream with rx_valid toggling
    bootReq0 = 1'b1;
    @(negedge clk);
    bootReq0 = 1'b0;
    check("t2_boot_cpu_reset", {31'd0, cpuReset0}, 32'd1);
    check("t2_boot_done", {31'd0, done0}, 32'd0);
    check("t2_boot_wc", {16'd0, wc0}, 32'd0);
    check("t2_boot_adr", adr0, 32'h0);
    sendByte(0, 8'h78, 1); sendByte(0, 8'h56, 1); sendByte(0, 8'h34, 1); sendByte(0, 8'h12, 1);
    sendByte(0, 8'hEF, 1); sendByte(0, 8'hBE, 1); sendByte(0, 8'hAD, 1); sendByte(0, 8'hDE, 1);
    check("t2_rel_cpu_reset", {31'd0, cpuReset0}, 32'd1);
    check("t2_rel_done", {31'd0, done0}, 32'd0);
    @(negedge clk);
    check("t2_run_done", {31'd0, done0}, 32'd1);
    check("t2_run_wc", {16'd0, wc0}, 32'd2);
    check("t2_nwr", nWr0, 4);
    check("t2_adr0", logAdr0[2], 32'h0);
    check("t2_dat0", logDat0[2], 32'h12345678);
    check("t2_adr1", logAdr0[3], 32'h4);
    check("t2_dat1", logDat0[3], 32'hDEADBEEF);

    // Bytes offered in RUN are not taken
    rxValid0 = 1'b1; rxData0 = 8'h55;
    repeat (5) begin
      @(negedge clk);
      check("run_ready", {31'd0, rxReady0}, 32'd0);
    end
    rxValid0 = 1'b0;
    check("run_wc", {16'd0, wc0}, 32'd2);
    check("run_done", {31'd0, done0}, 32'd1);
    check("run_nwr", nWr0, 4);

    // Reboot and load AA BB CC DD
    bootReq0 = 1'b1;
    @(negedge clk);
    bootReq0 = 1'b0;
    check("t4_boot_cpu_reset", {31'd0, cpuReset0}, 32'd1);
    check("t4_boot_done", {31'd0, done0}, 32'd0);
    sendByte(0, 8'hAA, 0); sendByte(0, 8'hBB, 0); sendByte(0, 8'hCC, 0); sendByte(0, 8'hDD, 0);
    check("t4_write_adr", adr0, 32'h0);
    check("t4_write_wd", wd0, 32'hDDCCBBAA);
    rxValid0 = 1'b0;
    @(negedge clk);
    check("t4_wc", {16'd0, wc0}, 32'd1);

    // Reset after two bytes of a word; the partial word must vanish
    sendByte(0, 8'h01, 0); sendByte(0, 8'h02, 0);
    rxValid0 = 1'b0;
    reset = 1'b1;
    #1;
    check("t3_rst_ready", {31'd0, rxReady0}, 32'd0);
    check("t3_rst_wc", {16'd0, wc0}, 32'd0);
    check("t3_rst_adr", adr0, 32'h0);
    check("t3_rst_cpu_reset", {31'd0, cpuReset0}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    sendByte(0, 8'h11, 0); sendByte(0, 8'h22, 0); sendByte(0, 8'h33, 0); sendByte(0, 8'h44, 0);
    check("t3_write_adr", adr0, 32'h0);
    check("t3_write_wd", wd0, 32'h44332211);
    sendByte(0, 8'h55, 0); sendByte(0, 8'h66, 0); sendByte(0, 8'h77, 0); sendByte(0, 8'h88, 0);
    check("t3_write2_adr", adr0, 32'h4);
    check("t3_write2_wd", wd0, 32'h88776655);
    rxValid0 = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_run_done", {31'd0, done0}, 32'd1);
    check("t3_run_wc", {16'd0, wc0}, 32'd2);
    check("t3_nwr", nWr0, 7);
    check("t4_log_adr", logAdr0[4], 32'h0);
    check("t4_log_dat", logDat0[4], 32'hDDCCBBAA);
    check("t3_log_dat", logDat0[5], 32'h44332211);
    check("t3_log_adr2", logAdr0[6], 32'h4);

    // Second instance: three words starting at 0x100
    for (int i = 1; i <= 12; i++) sendByte(1, 8'(i), 0);
    rxValid1 = 1'b0;
    repeat (2) @(negedge clk);
    check("b_run_done", {31'd0, done1}, 32'd1);
    check("b_run_cpu_reset", {31'd0, cpuReset1}, 32'd0);
    check("b_run_wc", {16'd0, wc1}, 32'd3);
    check("b_nwr", nWr1, 3);
    check("b_adr0", logAdr1[0], 32'h100);
    check("b_dat0", logDat1[0], 32'h04030201);
    check("b_adr1", logAdr1[1], 32'h104);
    check("b_dat1", logDat1[1], 32'h08070605);
    check("b_adr2", logAdr1[2], 32'h108);
    check("b_dat2", logDat1[2], 32'h0C0B0A09);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
